// File: rtl/mem_stage_pkg.sv
// Shared types and control-field positions for the MEM pipeline stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Bit positions inside the 3-bit {MemWrite, MemtoReg, RegWrite} control bundle
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 0;

    // Any instruction that touches data memory (a load sets MemtoReg, a store sets MemWrite)
    function automatic logic is_mem_op(input logic [2:0] ctrl);
        return ctrl[CTRL_MEMWRITE] | ctrl[CTRL_MEMTOREG];
    endfunction

endpackage

// File: rtl/D_FF_En_VAR.sv
// Variable-width D flip-flop with write enable and synchronous clear.
// Latency: 1 cycle from d to q when write_en is high.
// Backpressure: none; write_en low simply holds the stored value.
module D_FF_En_VAR #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: clear on reset, capture d when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (write_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wait_timer.sv
// Wait-state counter for an outstanding memory access; flags the last allowed cycle.
// Latency: expired is combinational from the count; count updates on the next edge.
// Backpressure: none; enable low holds the count, and it saturates rather than wrapping.
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count wait cycles; stop at LAST so the counter can never wrap back to zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues the data-memory access over req/ack and registers the MEM/WB boundary.
// Latency: 1 cycle for non-memory ops; loads/stores take 2 cycles minimum plus memory wait states.
// Backpressure: stall (combinational) holds EX/MEM while a request is pending, until ack or timeout.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ALU_LSR_result,
    input  logic [63:0] Db,
    input  logic [2:0]  control,
    input  logic [4:0]  Rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_Rd,
    output logic        wb_RegWrite,
    output logic        mem_fault
);

    mem_state_t state;

    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic mem_op;
    logic misaligned;
    logic in_idle;
    logic in_access;
    logic start;
    logic ack_done;
    logic timed_out;
    logic expired;
    logic complete;

    logic [63:0] wb_data_d;
    logic        wb_rw_d;

    assign mem_write  = control[CTRL_MEMWRITE];
    assign mem_to_reg = control[CTRL_MEMTOREG];
    assign reg_write  = control[CTRL_REGWRITE];
    assign mem_op     = is_mem_op(control);
    assign misaligned = mem_op && (ALU_LSR_result[2:0] != 3'b000);

    assign in_idle   = (state == IDLE);
    assign in_access = (state == ACCESS);

    // A misaligned access never reaches memory; it is faulted straight from IDLE
    assign start     = in_idle && mem_op && !misaligned;
    // Ack is only meaningful while a request is outstanding; ack beats timeout
    assign ack_done  = in_access && mem_ack;
    assign timed_out = in_access && !mem_ack && expired;

    // Upstream is released in the cycle the access finishes (ack or timeout)
    assign stall = start || (in_access && !mem_ack && !expired);

    // Instruction retires into MEM/WB either directly (no memory op) or on ack
    assign complete  = (in_idle && !mem_op) || ack_done;
    assign wb_data_d = (ack_done && mem_to_reg) ? mem_rdata : ALU_LSR_result;
    // Every other cycle is a bubble so a stalled instruction never writes twice
    assign wb_rw_d   = complete && reg_write;

    // Access FSM and request register: fields latched once at issue, held until ack or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= mem_write && !mem_to_reg;
            mem_addr  <= ALU_LSR_result;
            mem_wdata <= Db;
        end else if (ack_done || timed_out) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
        end
    end

    // Fault pulse: one cycle after a misaligned request or a wait-state timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= (in_idle && misaligned) || timed_out;
        end
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_access),
        .enable  (in_access && !mem_ack),
        .expired (expired)
    );

    D_FF_En_VAR #(.WIDTH(64)) u_wb_data (
        .clk      (clk),
        .reset    (reset),
        .write_en (1'b1),
        .d        (wb_data_d),
        .q        (wb_data)
    );

    D_FF_En_VAR #(.WIDTH(5)) u_wb_rd (
        .clk      (clk),
        .reset    (reset),
        .write_en (1'b1),
        .d        (Rd),
        .q        (wb_Rd)
    );

    D_FF_En_VAR #(.WIDTH(1)) u_wb_rw (
        .clk      (clk),
        .reset    (reset),
        .write_en (1'b1),
        .d        (wb_rw_d),
        .q        (wb_RegWrite)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, multi-cycle reset sequence, random ops.
// Latency: n/a (testbench).
// Backpressure: bench holds EX/MEM inputs while stall is high and plays the memory responder.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ALU_LSR_result;
    logic [63:0] Db;
    logic [2:0]  control;
    logic [4:0]  Rd;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [63:0] wb_data;
    logic [4:0]  wb_Rd;
    logic        wb_RegWrite;
    logic        mem_fault;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ALU_LSR_result (ALU_LSR_result),
        .Db             (Db),
        .control        (control),
        .Rd             (Rd),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .stall          (stall),
        .wb_data        (wb_data),
        .wb_Rd          (wb_Rd),
        .wb_RegWrite    (wb_RegWrite),
        .mem_fault      (mem_fault)
    );

    always #5 clk = ~clk;

    // Expected outcome of one instruction, described at transaction level
    typedef struct {
        int          stalls;   // cycles with stall=1
        int          reqs;     // cycles with mem_req=1
        logic        we;
        logic        wr;       // exactly one wb_RegWrite pulse at completion
        logic [63:0] data;
        logic [4:0]  rd;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [2:0]  ctrl;
        logic [63:0] res;
        logic [63:0] db;
        logic [4:0]  rd;
        int          dly;      // ACCESS cycles without ack before the ack cycle
        logic [63:0] rdata;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outcome from the architectural rules alone
    function automatic exp_t predict(input logic [2:0] c, input logic [63:0] res, input logic [4:0] r,
                                     input int dly, input logic [63:0] rdat);
        exp_t e;
        bit   op;
        e = '{stalls: 0, reqs: 0, we: 1'b0, wr: 1'b0, data: 64'h0, rd: r, fault: 1'b0};
        op = c[2] | c[1];
        if (!op) begin
            e.wr   = c[0];
            e.data = res;
        end else if (res[2:0] != 3'b000) begin
            e.fault = 1'b1;
        end else begin
            e.we = c[2] && !c[1];
            if (dly < TIMEOUT) begin
                e.stalls = dly + 1;
                e.reqs   = dly + 1;
                e.wr     = c[0];
                e.data   = c[1] ? rdat : res;
            end else begin
                e.stalls = TIMEOUT;
                e.reqs   = TIMEOUT;
                e.fault  = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk_exp(input int st, input int rq, input logic we, input logic wr,
                                    input logic [63:0] d, input logic [4:0] r, input logic f);
        exp_t e;
        e = '{stalls: st, reqs: rq, we: we, wr: wr, data: d, rd: r, fault: f};
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [2:0] c, input logic [63:0] res, input logic [63:0] db,
                                    input logic [4:0] r, input int dly, input logic [63:0] rdat, input exp_t e);
        vec_t v;
        v.ctrl = c; v.res = res; v.db = db; v.rd = r; v.dly = dly; v.rdata = rdat; v.e = e;
        return v;
    endfunction

    // Present one instruction, hold it while stalled, act as memory, then check the retirement
    task automatic run_instr(input vec_t v, input string nm);
        int   stalls = 0;
        int   reqs   = 0;
        int   badfld = 0;
        int   early  = 0;
        int   cyc    = 0;
        bit   fin    = 0;
        bit   idle_path;
        idle_path      = (v.e.reqs == 0);
        control        = v.ctrl;
        ALU_LSR_result = v.res;
        Db             = v.db;
        Rd             = v.rd;
        mem_ack        = 1'b0;
        mem_rdata      = {$urandom, $urandom};
        while (!fin && cyc < 64) begin
            cyc++;
            if (mem_req) begin
                reqs++;
                if (mem_addr !== v.res || mem_wdata !== v.db || mem_we !== v.e.we) badfld++;
            end
            if (wb_RegWrite || mem_fault) early++;
            // Spurious ack while no request is outstanding must be ignored
            mem_ack = (mem_req && reqs == v.dly + 1) || (idle_path && !mem_req);
            if (mem_ack) mem_rdata = v.rdata;
            #1;
            if (stall) stalls++;
            else fin = 1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        check({nm, " finished"}, 64'(fin), 64'd1);
        check({nm, " stall cycles"}, 64'(stalls), 64'(v.e.stalls));
        check({nm, " req cycles"}, 64'(reqs), 64'(v.e.reqs));
        check({nm, " req field errors"}, 64'(badfld), 64'd0);
        check({nm, " early wb/fault"}, 64'(early), 64'd0);
        check({nm, " wb_RegWrite"}, 64'(wb_RegWrite), 64'(v.e.wr));
        check({nm, " mem_fault"}, 64'(mem_fault), 64'(v.e.fault));
        check({nm, " mem_req after"}, 64'(mem_req), 64'd0);
        if (v.e.wr) begin
            check({nm, " wb_data"}, wb_data, v.e.data);
            check({nm, " wb_Rd"}, 64'(wb_Rd), 64'(v.e.rd));
        end
        // One bubble to confirm fault and write are single-cycle pulses
        control = 3'b000;
        Rd      = 5'd0;
        step();
        check({nm, " fault pulse width"}, 64'(mem_fault), 64'd0);
        check({nm, " write pulse width"}, 64'(wb_RegWrite), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Directed vectors (TIMEOUT = 16), expectations written out by hand
        tbl.push_back(mk_vec(3'b001, 64'h10,  64'h0,  5'd3,  0,  64'h0,
                             mk_exp(0,  0,  1'b0, 1'b1, 64'h10,   5'd3,  1'b0)));  // ADD
        tbl.push_back(mk_vec(3'b011, 64'h40,  64'h0,  5'd5,  3,  64'hDEAD,
                             mk_exp(4,  4,  1'b0, 1'b1, 64'hDEAD, 5'd5,  1'b0)));  // load, 3 waits
        tbl.push_back(mk_vec(3'b100, 64'h8,   64'h55, 5'd6,  1,  64'h0,
                             mk_exp(2,  2,  1'b1, 1'b0, 64'h0,    5'd6,  1'b0)));  // store, 1 wait
        tbl.push_back(mk_vec(3'b011, 64'h100, 64'h0,  5'd9,  99, 64'h0,
                             mk_exp(16, 16, 1'b0, 1'b0, 64'h0,    5'd9,  1'b0 | 1'b1))); // timeout
        tbl.push_back(mk_vec(3'b011, 64'h43,  64'h0,  5'd4,  0,  64'h0,
                             mk_exp(0,  0,  1'b0, 1'b0, 64'h0,    5'd4,  1'b1)));  // misaligned load
        tbl.push_back(mk_vec(3'b111, 64'h18,  64'h99, 5'd10, 0,  64'h1234,
                             mk_exp(1,  1,  1'b0, 1'b1, 64'h1234, 5'd10, 1'b0)));  // both set = load
        tbl.push_back(mk_vec(3'b011, 64'h20,  64'h0,  5'd11, 15, 64'hBEEF,
                             mk_exp(16, 16, 1'b0, 1'b1, 64'hBEEF, 5'd11, 1'b0)));  // ack on last cycle wins
        tbl.push_back(mk_vec(3'b101, 64'h30,  64'h77, 5'd12, 0,  64'hF00D,
                             mk_exp(1,  1,  1'b1, 1'b1, 64'h30,   5'd12, 1'b0)));  // store with RegWrite
        tbl.push_back(mk_vec(3'b100, 64'h9,   64'h1,  5'd13, 0,  64'h0,
                             mk_exp(0,  0,  1'b0, 1'b0, 64'h0,    5'd13, 1'b1)));  // misaligned store
        tbl.push_back(mk_vec(3'b000, 64'h7,   64'h0,  5'd14, 0,  64'h0,
                             mk_exp(0,  0,  1'b0, 1'b0, 64'h0,    5'd14, 1'b0)));  // nop, odd addr

        reset = 1'b1; control = 3'b000; ALU_LSR_result = '0; Db = '0; Rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset mem_we", 64'(mem_we), 64'd0);
        check("reset mem_addr", mem_addr, 64'd0);
        check("reset mem_wdata", mem_wdata, 64'd0);
        check("reset wb_data", wb_data, 64'd0);
        check("reset wb_Rd", 64'(wb_Rd), 64'd0);
        check("reset wb_RegWrite", 64'(wb_RegWrite), 64'd0);
        check("reset mem_fault", 64'(mem_fault), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            run_instr(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an access, then a late ack
        control = 3'b011; ALU_LSR_result = 64'h80; Db = '0; Rd = 5'd7; mem_ack = 1'b0;
        step(); step(); step();
        check("rst-seq req before reset", 64'(mem_req), 64'd1);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        control = 3'b000;
        #1;
        check("rst-seq mem_req", 64'(mem_req), 64'd0);
        check("rst-seq wb_RegWrite", 64'(wb_RegWrite), 64'd0);
        check("rst-seq wb_data", wb_data, 64'd0);
        check("rst-seq mem_fault", 64'(mem_fault), 64'd0);
        check("rst-seq stall", 64'(stall), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        #1;
        check("rst-seq late ack stall", 64'(stall), 64'd0);
        step();
        mem_ack = 1'b0;
        check("rst-seq late ack req", 64'(mem_req), 64'd0);
        check("rst-seq late ack write", 64'(wb_RegWrite), 64'd0);
        check("rst-seq late ack fault", 64'(mem_fault), 64'd0);
        run_instr(mk_vec(3'b001, 64'h10, 64'h0, 5'd3, 0, 64'h0,
                         mk_exp(0, 0, 1'b0, 1'b1, 64'h10, 5'd3, 1'b0)), "rst-seq add");

        // Random instructions against the transaction-level model
        for (int i = 0; i < 40; i++) begin
            v.ctrl  = 3'($urandom_range(0, 7));
            v.res   = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) v.res[2:0] = 3'b000;
            v.db    = {$urandom, $urandom};
            v.rd    = 5'($urandom_range(0, 31));
            v.dly   = $urandom_range(0, 19);
            v.rdata = {$urandom, $urandom};
            v.e     = predict(v.ctrl, v.res, v.rd, v.dly, v.rdata);
            run_instr(v, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
